// File: rtl/button_event_decoder.sv
// Turns the debounced button level into registered one-cycle event pulses
// (press, release, short, long, auto-repeat) plus a registered held flag.
module button_event_decoder #(
  parameter int LONG_TIME   = 10_000_000,
  parameter int REPEAT_TIME = 2_500_000,
  parameter int CNT_LEN     = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  input  logic enable,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } state_e;

  // Thresholds are compared against the value the counter holds on the
  // sampling edge, so the last count before a threshold is TIME-1.
  localparam logic [CNT_LEN-1:0] LONG_LAST   = CNT_LEN'(LONG_TIME - 1);
  localparam bit                 REPEAT_EN   = (REPEAT_TIME != 0);
  localparam logic [CNT_LEN-1:0] REPEAT_LAST = REPEAT_EN ? CNT_LEN'(REPEAT_TIME - 1) : '0;
  localparam logic [CNT_LEN-1:0] CNT_ONE     = CNT_LEN'(1);

  state_e             state_q, state_d;
  logic [CNT_LEN-1:0] cnt_q, cnt_d;
  logic               btn_q, btn_d;
  logic               press_q, press_d;
  logic               release_q, release_d;
  logic               short_q, short_d;
  logic               long_q, long_d;
  logic               repeat_q, repeat_d;
  logic               held_q, held_d;

  logic rise;
  logic fall;

  assign rise = btn_level & ~btn_q;
  assign fall = ~btn_level & btn_q;

  // btn_q follows the input even while disabled, so a button already down
  // when enable returns produces no rise until it is released and re-pressed.
  assign btn_d = btn_level;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (rise) begin
            press_d = 1'b1;
            state_d = ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          // A release on the threshold cycle wins: short, not long.
          if (fall) begin
            release_d = 1'b1;
            short_d   = 1'b1;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else if (cnt_q == LONG_LAST) begin
            long_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_LONG_HELD;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_LONG_HELD: begin
          if (fall) begin
            release_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else if (REPEAT_EN && (cnt_q == REPEAT_LAST)) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else if (REPEAT_EN) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    held_d = enable && (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_q     <= btn_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_pulse   = short_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;

endmodule
